// File: rtl/rvl_mbox_responder.sv
// rtl/rvl_mbox_responder.sv - user-clock mailbox responder executing debugger register commands
module rvl_mbox_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int POLL_DIV   = 256,
    parameter int TIMEOUT    = 1024,
    parameter int BUF_BASE   = 16
) (
    input  logic                  usr_clk,
    input  logic                  usr_rst_n,
    output logic                  usr_ce,
    output logic                  usr_we,
    output logic [ADDR_WIDTH-1:0] usr_addr,
    output logic [DATA_WIDTH-1:0] usr_wdata,
    input  logic [DATA_WIDTH-1:0] usr_rdata,
    output logic                  reg_req,
    output logic                  reg_we,
    output logic [DATA_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic                  reg_ack,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_CMD, S_CHK_CMD, S_RD_BASE, S_CAP_BASE, S_RD_BUF,
        S_CAP_BUF, S_BUS, S_WR_BUF, S_WR_STAT, S_CLR_CMD
    } state_t;

    // RD_CMD and CHK_CMD are part of the poll period, so the idle reload is shortened by two.
    localparam int POLL_RELOAD = (POLL_DIV >= 3) ? POLL_DIV - 3 : 0;

    state_t                state_q, state_d;
    logic [31:0]           poll_q, poll_d;
    logic [31:0]           wait_q, wait_d;
    logic [DATA_WIDTH-1:0] cmd_q, cmd_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic [7:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [ADDR_WIDTH-1:0] buf_addr;
    logic                  last_item;
    logic [2:0]            opcode;

    assign buf_addr  = ADDR_WIDTH'(BUF_BASE) + ADDR_WIDTH'(idx_q);
    assign last_item = ((idx_q + 8'd1) == cmd_q[7:0]);
    assign opcode    = usr_rdata[30:28];

    assign busy      = busy_q;
    assign reg_we    = we_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;

    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            state_q <= S_IDLE;
            poll_q  <= 32'(POLL_DIV - 1);
            wait_q  <= '0;
            cmd_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            poll_q  <= poll_d;
            wait_q  <= wait_d;
            cmd_q   <= cmd_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        poll_d    = poll_q;
        wait_d    = wait_q;
        cmd_d     = cmd_q;
        err_d     = err_q;
        busy_d    = busy_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        usr_ce    = 1'b0;
        usr_we    = 1'b0;
        usr_addr  = '0;
        usr_wdata = '0;
        reg_req   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (poll_q == 32'd0) state_d = S_RD_CMD;
                else                 poll_d  = poll_q - 32'd1;
            end
            S_RD_CMD: begin
                usr_ce  = 1'b1;
                state_d = S_CHK_CMD;
            end
            S_CHK_CMD: begin
                cmd_d = usr_rdata;
                idx_d = '0;
                err_d = 1'b0;
                if (!usr_rdata[31]) begin
                    poll_d  = 32'(POLL_RELOAD);
                    state_d = S_IDLE;
                end else if (opcode != 3'd1 && opcode != 3'd2) begin
                    err_d   = 1'b1;
                    state_d = S_WR_STAT;
                end else begin
                    busy_d  = 1'b1;
                    we_d    = (opcode == 3'd1);
                    state_d = S_RD_BASE;
                end
            end
            S_RD_BASE: begin
                usr_ce   = 1'b1;
                usr_addr = ADDR_WIDTH'(1);
                state_d  = S_CAP_BASE;
            end
            S_CAP_BASE: begin
                addr_d = usr_rdata;
                wait_d = '0;
                if (cmd_q[7:0] == 8'd0) state_d = S_WR_STAT;
                else if (we_q)          state_d = S_RD_BUF;
                else                    state_d = S_BUS;
            end
            S_RD_BUF: begin
                usr_ce   = 1'b1;
                usr_addr = buf_addr;
                state_d  = S_CAP_BUF;
            end
            S_CAP_BUF: begin
                wdata_d = usr_rdata;
                wait_d  = '0;
                state_d = S_BUS;
            end
            S_BUS: begin
                reg_req = 1'b1;
                if (reg_ack) begin
                    if (we_q) begin
                        idx_d   = idx_q + 8'd1;
                        addr_d  = addr_q + 1'b1;
                        state_d = last_item ? S_WR_STAT : S_RD_BUF;
                    end else begin
                        rdata_d = reg_rdata;
                        state_d = S_WR_BUF;
                    end
                end else if (wait_q == 32'(TIMEOUT - 1)) begin
                    // Abandon the rest of the burst; idx_q still counts only acked items.
                    err_d   = 1'b1;
                    state_d = S_WR_STAT;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            S_WR_BUF: begin
                usr_ce    = 1'b1;
                usr_we    = 1'b1;
                usr_addr  = buf_addr;
                usr_wdata = rdata_q;
                idx_d     = idx_q + 8'd1;
                addr_d    = addr_q + 1'b1;
                wait_d    = '0;
                state_d   = last_item ? S_WR_STAT : S_BUS;
            end
            S_WR_STAT: begin
                usr_ce           = 1'b1;
                usr_we           = 1'b1;
                usr_addr         = ADDR_WIDTH'(2);
                usr_wdata[31:0]  = {1'b1, err_q, 6'b0, cmd_q[23:16], 8'b0, idx_q};
                state_d          = S_CLR_CMD;
            end
            S_CLR_CMD: begin
                usr_ce        = 1'b1;
                usr_we        = 1'b1;
                usr_wdata     = cmd_q;
                usr_wdata[31] = 1'b0;
                busy_d        = 1'b0;
                poll_d        = 32'(POLL_RELOAD);
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rvl_mbox_responder.sv
// tb/tb_rvl_mbox_responder.sv - directed self-checking bench for rvl_mbox_responder
module tb_rvl_mbox_responder;

    logic        usr_clk = 1'b0;
    logic        usr_rst_n = 1'b0;
    logic        usr_ce, usr_we;
    logic [15:0] usr_addr;
    logic [31:0] usr_wdata, usr_rdata;
    logic        reg_req, reg_we, reg_ack;
    logic [31:0] reg_addr, reg_wdata, reg_rdata;
    logic        busy;

    rvl_mbox_responder #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .POLL_DIV(4), .TIMEOUT(16), .BUF_BASE(16)
    ) dut (
        .usr_clk(usr_clk), .usr_rst_n(usr_rst_n),
        .usr_ce(usr_ce), .usr_we(usr_we), .usr_addr(usr_addr),
        .usr_wdata(usr_wdata), .usr_rdata(usr_rdata),
        .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_ack(reg_ack), .reg_rdata(reg_rdata),
        .busy(busy)
    );

    always #5 usr_clk = ~usr_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Mailbox RAM with a second (debugger) write port and a monitor of DUT activity.
    logic [31:0] mem [0:255];
    logic [7:0]  raddr = 8'd0;
    logic        dbg_we = 1'b0;
    logic [7:0]  dbg_addr = 8'd0;
    logic [31:0] dbg_wdata = 32'd0;
    int          cyc = 0, ce_n = 0, wr_n = 0, stat_n = 0, rd0_n = 0, req_cyc = 0;
    int          req_run = 0, last_run = 0;
    int          rd0_cyc [0:4095];

    assign usr_rdata = mem[raddr];

    always @(posedge usr_clk) begin
        cyc <= cyc + 1;
        if (dbg_we) mem[dbg_addr] <= dbg_wdata;
        if (usr_ce && usr_we) begin
            mem[usr_addr[7:0]] <= usr_wdata;
            wr_n <= wr_n + 1;
            if (usr_addr == 16'd2) stat_n <= stat_n + 1;
        end
        if (usr_ce && !usr_we) begin
            raddr <= usr_addr[7:0];
            if (usr_addr == 16'd0) begin
                rd0_cyc[rd0_n % 4096] <= cyc;
                rd0_n <= rd0_n + 1;
            end
        end
        if (usr_ce) ce_n <= ce_n + 1;
        if (reg_req) begin
            req_cyc <= req_cyc + 1;
            req_run <= req_run + 1;
        end else if (req_run != 0) begin
            last_run <= req_run;
            req_run  <= 0;
        end
    end

    // Register slave: per-item ack delay, optional never-acking item.
    int          xf_n = 0, d_base = 0, wcnt = 0, never_idx = -1, cur_idx;
    int          delays [0:15];
    logic [31:0] rd_vals [0:15];
    logic        xf_we [0:63];
    logic [31:0] xf_addr [0:63];
    logic [31:0] xf_wdata [0:63];

    always_comb cur_idx = xf_n - d_base;
    assign reg_ack   = reg_req && (cur_idx != never_idx) && (wcnt == delays[cur_idx[3:0]]);
    assign reg_rdata = rd_vals[cur_idx[3:0]];

    always @(posedge usr_clk) begin
        if (!reg_req) wcnt <= 0;
        else if (reg_ack) begin
            xf_we[xf_n % 64]    <= reg_we;
            xf_addr[xf_n % 64]  <= reg_addr;
            xf_wdata[xf_n % 64] <= reg_wdata;
            xf_n <= xf_n + 1;
            wcnt <= 0;
        end else wcnt <= wcnt + 1;
    end

    task automatic dbg_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge usr_clk);
        dbg_addr  = a;
        dbg_wdata = d;
        dbg_we    = 1'b1;
        @(posedge usr_clk);
        #1 dbg_we = 1'b0;
    endtask

    task automatic wait_go_clear(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge usr_clk);
            if (!mem[0][31] && !busy) ok = 1'b1;
        end
        repeat (2) @(negedge usr_clk);
    endtask

    task automatic set_slave(input int d0, input int d1, input int d2, input int nev);
        for (int k = 0; k < 16; k++) begin
            delays[k]  = 0;
            rd_vals[k] = 32'h0;
        end
        delays[0] = d0;
        delays[1] = d1;
        delays[2] = d2;
        never_idx = nev;
        d_base    = xf_n;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 16; k++) begin
            delays[k]  = 0;
            rd_vals[k] = 32'h0;
        end
        for (int a = 0; a < 32; a++) dbg_write(8'(a), 32'h0);
        @(negedge usr_clk);
        n_cmp++;
        if ({usr_ce, usr_we, usr_addr, usr_wdata, busy} !== 50'h0) begin
            n_bad++;
            $display("FAIL reset_mbox_outputs: got %h required 0", {usr_ce, usr_we, usr_addr, usr_wdata, busy});
        end
        n_cmp++;
        if ({reg_req, reg_we, reg_addr, reg_wdata} !== 66'h0) begin
            n_bad++;
            $display("FAIL reset_reg_outputs: got %h required 0", {reg_req, reg_we, reg_addr, reg_wdata});
        end
        usr_rst_n = 1'b1;
        @(posedge usr_clk);
        #1;
        n_cmp++;
        if (usr_ce !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_first_cycle_ce: got %b required 0", usr_ce);
        end
    endtask

    task automatic test_idle_poll;
        int ce0, rd00, wr0, rq0;
        logic busy_seen;
        repeat (8) @(negedge usr_clk);
        ce0 = ce_n; rd00 = rd0_n; wr0 = wr_n; rq0 = req_cyc; busy_seen = 1'b0;
        repeat (40) begin
            @(negedge usr_clk);
            busy_seen = busy_seen | busy;
        end
        n_cmp++;
        if (rd0_n - rd00 !== 10) begin
            n_bad++;
            $display("FAIL idle_poll_count: got %0d required 10", rd0_n - rd00);
        end
        for (int k = rd00 + 1; k < rd0_n; k++) begin
            n_cmp++;
            if (rd0_cyc[k % 4096] - rd0_cyc[(k - 1) % 4096] !== 4) begin
                n_bad++;
                $display("FAIL idle_poll_interval: got %0d required 4", rd0_cyc[k % 4096] - rd0_cyc[(k - 1) % 4096]);
            end
        end
        n_cmp++;
        if (ce_n - ce0 !== rd0_n - rd00) begin
            n_bad++;
            $display("FAIL idle_only_cmd_reads: got %0d ce required %0d", ce_n - ce0, rd0_n - rd00);
        end
        n_cmp++;
        if ({busy_seen, 32'(wr_n - wr0), 32'(req_cyc - rq0)} !== 65'h0) begin
            n_bad++;
            $display("FAIL idle_quiet: got busy=%b writes=%0d req=%0d required 0", busy_seen, wr_n - wr0, req_cyc - rq0);
        end
    endtask

    task automatic test_single_write;
        int x0;
        bit ok;
        set_slave(0, 0, 0, -1);
        x0 = xf_n;
        dbg_write(8'd2, 32'h0);
        dbg_write(8'd1, 32'h100);
        dbg_write(8'd16, 32'hDEADBEEF);
        dbg_write(8'd0, 32'h9005_0001);
        wait_go_clear(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL single_done: got timeout required completion"); end
        n_cmp++;
        if (xf_n - x0 !== 1) begin n_bad++; $display("FAIL single_xfer_count: got %0d required 1", xf_n - x0); end
        n_cmp++;
        if ({xf_we[x0 % 64], xf_addr[x0 % 64], xf_wdata[x0 % 64]} !== {1'b1, 32'h100, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL single_xfer: got we=%b addr=%h data=%h required 1 00000100 deadbeef",
                     xf_we[x0 % 64], xf_addr[x0 % 64], xf_wdata[x0 % 64]);
        end
        n_cmp++;
        if (mem[2] !== 32'h8005_0001) begin n_bad++; $display("FAIL single_status: got %h required 80050001", mem[2]); end
        n_cmp++;
        if (mem[0] !== 32'h1005_0001) begin n_bad++; $display("FAIL single_cmd_clear: got %h required 10050001", mem[0]); end
    endtask

    task automatic test_burst_read;
        int x0;
        bit ok;
        set_slave(0, 2, 5, -1);
        rd_vals[0] = 32'hA0; rd_vals[1] = 32'hA1; rd_vals[2] = 32'hA2;
        x0 = xf_n;
        dbg_write(8'd2, 32'h0);
        dbg_write(8'd1, 32'h20);
        dbg_write(8'd0, 32'hA012_0003);
        wait_go_clear(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL burst_done: got timeout required completion"); end
        n_cmp++;
        if (xf_n - x0 !== 3) begin n_bad++; $display("FAIL burst_xfer_count: got %0d required 3", xf_n - x0); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({xf_we[(x0 + k) % 64], xf_addr[(x0 + k) % 64]} !== {1'b0, 32'h20 + 32'(k)}) begin
                n_bad++;
                $display("FAIL burst_addr%0d: got we=%b addr=%h required 0 %h", k, xf_we[(x0 + k) % 64],
                         xf_addr[(x0 + k) % 64], 32'h20 + 32'(k));
            end
            n_cmp++;
            if (mem[16 + k] !== 32'hA0 + 32'(k)) begin
                n_bad++;
                $display("FAIL burst_buf%0d: got %h required %h", k, mem[16 + k], 32'hA0 + 32'(k));
            end
        end
        n_cmp++;
        if (mem[2] !== 32'h8012_0003) begin n_bad++; $display("FAIL burst_status: got %h required 80120003", mem[2]); end
        n_cmp++;
        if (mem[0] !== 32'h2012_0003) begin n_bad++; $display("FAIL burst_cmd_clear: got %h required 20120003", mem[0]); end
    endtask

    task automatic test_timeout;
        int x0;
        bit ok;
        set_slave(0, 0, 0, 1);
        x0 = xf_n;
        dbg_write(8'd2, 32'h0);
        dbg_write(8'd1, 32'h40);
        dbg_write(8'd16, 32'h11);
        dbg_write(8'd17, 32'h22);
        dbg_write(8'd18, 32'h33);
        dbg_write(8'd19, 32'h44);
        dbg_write(8'd0, 32'h9033_0004);
        wait_go_clear(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL timeout_done: got timeout required completion"); end
        n_cmp++;
        if (xf_n - x0 !== 1) begin n_bad++; $display("FAIL timeout_xfer_count: got %0d required 1", xf_n - x0); end
        n_cmp++;
        if ({xf_addr[x0 % 64], xf_wdata[x0 % 64]} !== {32'h40, 32'h11}) begin
            n_bad++;
            $display("FAIL timeout_first_xfer: got addr=%h data=%h required 00000040 00000011", xf_addr[x0 % 64], xf_wdata[x0 % 64]);
        end
        n_cmp++;
        if (last_run !== 16) begin n_bad++; $display("FAIL timeout_req_length: got %0d required 16", last_run); end
        n_cmp++;
        if (mem[2] !== 32'hC033_0001) begin n_bad++; $display("FAIL timeout_status: got %h required c0330001", mem[2]); end
        n_cmp++;
        if (mem[0] !== 32'h1033_0004) begin n_bad++; $display("FAIL timeout_cmd_clear: got %h required 10330004", mem[0]); end
    endtask

    task automatic test_bad_opcode_and_count0;
        int rq0;
        bit ok;
        set_slave(0, 0, 0, -1);
        rq0 = req_cyc;
        dbg_write(8'd2, 32'h0);
        dbg_write(8'd0, 32'hD044_0002);
        wait_go_clear(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL badop_done: got timeout required completion"); end
        n_cmp++;
        if (mem[2] !== 32'hC044_0000) begin n_bad++; $display("FAIL badop_status: got %h required c0440000", mem[2]); end
        n_cmp++;
        if (mem[0] !== 32'h5044_0002) begin n_bad++; $display("FAIL badop_cmd_clear: got %h required 50440002", mem[0]); end
        n_cmp++;
        if (req_cyc - rq0 !== 0) begin n_bad++; $display("FAIL badop_no_req: got %0d required 0", req_cyc - rq0); end

        rq0 = req_cyc;
        dbg_write(8'd2, 32'h0);
        dbg_write(8'd1, 32'h77);
        dbg_write(8'd0, 32'h9055_0000);
        wait_go_clear(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL count0_done: got timeout required completion"); end
        n_cmp++;
        if (mem[2] !== 32'h8055_0000) begin n_bad++; $display("FAIL count0_status: got %h required 80550000", mem[2]); end
        n_cmp++;
        if (mem[0] !== 32'h1055_0000) begin n_bad++; $display("FAIL count0_cmd_clear: got %h required 10550000", mem[0]); end
        n_cmp++;
        if (req_cyc - rq0 !== 0) begin n_bad++; $display("FAIL count0_no_req: got %0d required 0", req_cyc - rq0); end
    endtask

    task automatic test_reset_mid_burst;
        int s0, x0;
        bit hit, ok;
        set_slave(3, 3, 3, -1);
        rd_vals[0] = 32'hB0; rd_vals[1] = 32'hB1; rd_vals[2] = 32'hB2;
        dbg_write(8'd2, 32'h0);
        dbg_write(8'd16, 32'h0);
        dbg_write(8'd17, 32'h0);
        dbg_write(8'd18, 32'h0);
        dbg_write(8'd1, 32'h30);
        s0 = stat_n;
        dbg_write(8'd0, 32'hA066_0003);
        hit = 1'b0;
        for (int k = 0; k < 500 && !hit; k++) begin
            @(negedge usr_clk);
            if (cur_idx == 1 && reg_req) hit = 1'b1;
        end
        n_cmp++;
        if (hit !== 1'b1) begin n_bad++; $display("FAIL midrst_reach_item1: got timeout required second BUS cycle"); end
        usr_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({usr_ce, usr_we, usr_addr, usr_wdata, busy, reg_req, reg_we, reg_addr, reg_wdata} !== 116'h0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got %h required 0",
                     {usr_ce, usr_we, usr_addr, usr_wdata, busy, reg_req, reg_we, reg_addr, reg_wdata});
        end
        repeat (2) @(negedge usr_clk);
        n_cmp++;
        if ({32'(stat_n - s0), mem[2], mem[0]} !== {32'h0, 32'h0, 32'hA066_0003}) begin
            n_bad++;
            $display("FAIL midrst_no_status: got writes=%0d status=%h cmd=%h required 0 0 a0660003", stat_n - s0, mem[2], mem[0]);
        end
        d_base = xf_n;
        x0 = xf_n;
        usr_rst_n = 1'b1;
        wait_go_clear(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL midrst_done: got timeout required completion"); end
        n_cmp++;
        if (xf_n - x0 !== 3) begin n_bad++; $display("FAIL midrst_xfer_count: got %0d required 3", xf_n - x0); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({xf_addr[(x0 + k) % 64], mem[16 + k]} !== {32'h30 + 32'(k), 32'hB0 + 32'(k)}) begin
                n_bad++;
                $display("FAIL midrst_item%0d: got addr=%h buf=%h required %h %h", k, xf_addr[(x0 + k) % 64],
                         mem[16 + k], 32'h30 + 32'(k), 32'hB0 + 32'(k));
            end
        end
        n_cmp++;
        if (mem[2] !== 32'h8066_0003) begin n_bad++; $display("FAIL midrst_status: got %h required 80660003", mem[2]); end
        n_cmp++;
        if (mem[0] !== 32'h2066_0003) begin n_bad++; $display("FAIL midrst_cmd_clear: got %h required 20660003", mem[0]); end
    endtask

    initial begin
        test_reset();
        test_idle_poll();
        test_single_write();
        test_burst_read();
        test_timeout();
        test_bad_opcode_and_count0();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
